cmp_streak_monitor: RTL and testbench
=====================================

CMP_STREAK_MONITOR -- requirements
Module: cmp_streak_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of each outcome counter (legal 2..16).
REQ-002 Parameter RUN_LEN, default 4: consecutive identical outcomes that constitute a streak (legal 2..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  g/l pair valid this cycle.
REQ-006 g  input  1  greater-than flag from the upstream 2-bit comparator.
REQ-007 l  input  1  less-than flag from the upstream 2-bit comparator.
REQ-008 clear  input  1  synchronous clear of counters, streak state and error flag.
REQ-009 snap  input  1  request a snapshot of the three counters.
REQ-010 out_ready  input  1  consumer accepts the snapshot.
REQ-011 out_valid  output  1  snapshot held on out_* outputs.
REQ-012 out_gt_cnt, out_lt_cnt, out_eq_cnt  output  CNT_W each  snapshot counter values.
REQ-013 streak_dir  output  2  class of current locked streak: 00 none, 01 GT, 10 LT, 11 EQ.
REQ-014 streak_hit  output  1  one-cycle pulse when a streak first reaches RUN_LEN.
REQ-015 err  output  1  sticky flag: illegal g=l=1 sample seen.

Function
REQ-016 A sample SHALL be consumed only in cycles with in_valid=1; g/l are ignored otherwise.
REQ-017 Classification SHALL be: g=1,l=0 GT; g=0,l=1 LT; g=0,l=0 EQ; g=1,l=1 ILLEGAL.
REQ-018 An ILLEGAL sample SHALL set err the next cycle, increment no counter, and leave streak state unchanged.
REQ-019 Each legal sample SHALL increment its class counter by 1, visible one cycle later; counters saturate at 2^CNT_W-1 (no wrap).
REQ-020 Streak FSM states: IDLE (no prior sample), TRACK (run < RUN_LEN), LOCKED (run >= RUN_LEN).
REQ-021 IDLE: legal sample -> TRACK, run=1, last_class=sample class.
REQ-022 TRACK: same class -> run+1; run+1 = RUN_LEN -> LOCKED, streak_hit=1 for exactly that cycle after, streak_dir=class.
REQ-023 TRACK or LOCKED: different legal class -> TRACK, run=1, last_class=new class, streak_dir=00.
REQ-024 LOCKED: same class -> stay LOCKED, run saturates at RUN_LEN, no further streak_hit.
REQ-025 Snapshot: snap=1 while out_valid=0 -> next cycle out_valid=1, out_* = counter values at the snap edge, including any increment from that cycle's sample.
REQ-026 out_* and out_valid SHALL remain stable while out_valid=1 and out_ready=0; snap ignored in that interval.
REQ-027 out_valid=1 and out_ready=1 -> out_valid=0 next cycle; snap in the same cycle is ignored (one idle cycle between snapshots).
REQ-028 clear=1 SHALL zero counters, set FSM to IDLE, run=0, streak_dir=00, err=0 next cycle; a same-cycle sample is discarded (clear wins).
REQ-029 clear and snap in the same cycle: snapshot captures pre-clear values, counting no sample from that cycle.
REQ-030 clear SHALL NOT affect a pending snapshot (out_valid, out_*).

Reset
REQ-031 rst_n=0 SHALL immediately force: counters 0, FSM IDLE, run 0, streak_dir 00, streak_hit 0, err 0, out_valid 0, out_* 0.
REQ-032 Reset assertion mid-streak or mid-handshake SHALL discard all state; no snapshot survives.
REQ-033 Deassertion SHALL be synchronised externally; first active edge after release processes normally.

Structure
REQ-034 Shared package SHALL hold the 2-bit class encoding (NONE/GT/LT/EQ) and the FSM state encoding.
REQ-035 One sub-module, sat_counter (width-parameterised, inc/clear, saturating), SHALL be instantiated three times.

Verification
REQ-036 Reset, then GT,GT,GT,GT (RUN_LEN=4) -> streak_hit pulse one cycle after the 4th, streak_dir=01, gt count 4.
REQ-037 GT,GT,LT,LT,LT,LT -> no hit after GT pair; hit after 4th LT, streak_dir=10; counts gt=2, lt=4.
REQ-038 CNT_W=2, six EQ samples then snap -> out_eq_cnt=3 (saturated), out_valid held 5 cycles with out_ready=0, values stable.
REQ-039 g=l=1 sample mid-GT-run of 2, then GT,GT -> err=1, hit on the 4th GT overall, gt count 4.
REQ-040 clear, snap and in_valid(GT) same cycle with gt=5 -> out_gt_cnt=5, counters 0 next cycle, FSM IDLE.
REQ-041 rst_n low mid-TRACK with out_valid=1 -> all outputs 0 immediately, before next clock edge.

Source files
------------

// File: rtl/cmp_streak_monitor_pkg.sv
// Shared encodings for the comparator streak monitor: outcome classes and
// streak FSM states, plus the g/l classification helper.
package cmp_streak_monitor_pkg;

  localparam logic [1:0] CLS_NONE = 2'b00;
  localparam logic [1:0] CLS_GT   = 2'b01;
  localparam logic [1:0] CLS_LT   = 2'b10;
  localparam logic [1:0] CLS_EQ   = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_TRACK  = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  // g=l=1 has no legal meaning; it maps to CLS_NONE and is handled as an error.
  function automatic logic [1:0] classify(input logic g, input logic l);
    logic [1:0] cls;
    case ({g, l})
      2'b10:   cls = CLS_GT;
      2'b01:   cls = CLS_LT;
      2'b00:   cls = CLS_EQ;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Exposes the value it will
// hold after the coming edge so a snapshot can include this cycle's increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] next_count
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count;

  always_comb begin
    next_count = count;
    if (inc && (count != MAX)) next_count = count + W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (clear) count <= '0;
    else            count <= next_count;
  end

endmodule

// File: rtl/cmp_streak_monitor.sv
// Counts GT/LT/EQ outcomes from an upstream 2-bit comparator, detects runs of
// RUN_LEN identical outcomes, flags illegal g=l=1 samples, and offers
// ready/valid snapshots of the three counters.
module cmp_streak_monitor
  import cmp_streak_monitor_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             g,
  input  logic             l,
  input  logic             clear,
  input  logic             snap,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_gt_cnt,
  output logic [CNT_W-1:0] out_lt_cnt,
  output logic [CNT_W-1:0] out_eq_cnt,
  output logic [1:0]       streak_dir,
  output logic             streak_hit,
  output logic             err
);

  localparam logic [7:0] RUN_TGT = 8'(RUN_LEN);

  logic [1:0]       sample_cls;
  logic             legal;
  logic             illegal;
  logic [CNT_W-1:0] gt_next, lt_next, eq_next;

  logic [1:0] state;
  logic [1:0] last_class;
  logic [7:0] run;

  assign sample_cls = classify(g, l);
  assign legal      = in_valid && !(g && l);
  assign illegal    = in_valid && g && l;

  // Increments are gated by clear so a snapshot taken alongside a clear sees
  // the pre-clear totals without that cycle's sample.
  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .inc(legal && !clear && (sample_cls == CLS_GT)), .next_count(gt_next)
  );
  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .inc(legal && !clear && (sample_cls == CLS_LT)), .next_count(lt_next)
  );
  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .inc(legal && !clear && (sample_cls == CLS_EQ)), .next_count(eq_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_class <= CLS_NONE;
      run        <= '0;
      streak_dir <= CLS_NONE;
      streak_hit <= 1'b0;
      err        <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      last_class <= CLS_NONE;
      run        <= '0;
      streak_dir <= CLS_NONE;
      streak_hit <= 1'b0;
      err        <= 1'b0;
    end else begin
      streak_hit <= 1'b0;
      if (illegal) err <= 1'b1;
      if (legal) begin
        case (state)
          ST_IDLE: begin
            state      <= ST_TRACK;
            run        <= 8'd1;
            last_class <= sample_cls;
          end
          ST_TRACK, ST_LOCKED: begin
            if (sample_cls != last_class) begin
              state      <= ST_TRACK;
              run        <= 8'd1;
              last_class <= sample_cls;
              streak_dir <= CLS_NONE;
            end else if (state == ST_TRACK) begin
              if ((run + 8'd1) == RUN_TGT) begin
                state      <= ST_LOCKED;
                run        <= RUN_TGT;
                streak_hit <= 1'b1;
                streak_dir <= sample_cls;
              end else begin
                run <= run + 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Snapshot holder is untouched by clear; only reset or a handshake drops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_gt_cnt <= '0;
      out_lt_cnt <= '0;
      out_eq_cnt <= '0;
    end else if (out_valid) begin
      if (out_ready) out_valid <= 1'b0;
    end else if (snap) begin
      out_valid  <= 1'b1;
      out_gt_cnt <= gt_next;
      out_lt_cnt <= lt_next;
      out_eq_cnt <= eq_next;
    end
  end

endmodule

// File: tb/tb_cmp_streak_monitor.sv
// Self-checking bench: two instances (CNT_W=8 and CNT_W=2) share stimulus;
// snapshot expectations flow through a scoreboard queue.
module tb_cmp_streak_monitor;

  logic clk = 1'b0;
  logic rst_n, in_valid, g, l, clear, snap, out_ready;

  logic       out_valid, streak_hit, err;
  logic [7:0] out_gt_cnt, out_lt_cnt, out_eq_cnt;
  logic [1:0] streak_dir;

  logic       d2_out_valid, d2_streak_hit, d2_err;
  logic [1:0] d2_out_gt_cnt, d2_out_lt_cnt, d2_out_eq_cnt;
  logic [1:0] d2_streak_dir;

  cmp_streak_monitor #(.CNT_W(8), .RUN_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .l(l),
    .clear(clear), .snap(snap), .out_ready(out_ready),
    .out_valid(out_valid), .out_gt_cnt(out_gt_cnt), .out_lt_cnt(out_lt_cnt),
    .out_eq_cnt(out_eq_cnt), .streak_dir(streak_dir), .streak_hit(streak_hit),
    .err(err)
  );

  cmp_streak_monitor #(.CNT_W(2), .RUN_LEN(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .g(g), .l(l),
    .clear(clear), .snap(snap), .out_ready(out_ready),
    .out_valid(d2_out_valid), .out_gt_cnt(d2_out_gt_cnt), .out_lt_cnt(d2_out_lt_cnt),
    .out_eq_cnt(d2_out_eq_cnt), .streak_dir(d2_streak_dir), .streak_hit(d2_streak_hit),
    .err(d2_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] gt, lt, eq;
    logic [1:0] gt2, lt2, eq2;
  } snap_t;
  snap_t sb[$];

  // Unbounded model counts; each instance's expectation saturates them.
  int m_gt, m_lt, m_eq;

  function automatic logic [7:0] sat8(input int v);
    logic [31:0] t;
    t = (v > 255) ? 255 : v;
    return t[7:0];
  endfunction

  function automatic logic [1:0] sat2(input int v);
    logic [31:0] t;
    t = (v > 3) ? 3 : v;
    return t[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_sample(input logic gg, input logic ll);
    case ({gg, ll})
      2'b10: m_gt++;
      2'b01: m_lt++;
      2'b00: m_eq++;
      default: ;
    endcase
  endtask

  task automatic send(input logic gg, input logic ll);
    in_valid = 1'b1; g = gg; l = ll;
    tick();
    in_valid = 1'b0; g = 1'b0; l = 1'b0;
    model_sample(gg, ll);
  endtask

  task automatic push_expected();
    sb.push_back('{gt: sat8(m_gt), lt: sat8(m_lt), eq: sat8(m_eq),
                   gt2: sat2(m_gt), lt2: sat2(m_lt), eq2: sat2(m_eq)});
  endtask

  task automatic request_snap();
    snap = 1'b1;
    tick();
    snap = 1'b0;
    push_expected();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_gt = 0; m_lt = 0; m_eq = 0;
    checks++;
    if ({streak_dir, streak_hit, err} !== 4'b0) begin
      errors++;
      $display("FAIL clear_state got dir=%b hit=%b err=%b want 0/0/0", streak_dir, streak_hit, err);
    end
  endtask

  task automatic check_snapshot(input string name, input int hold, input bit disturb);
    snap_t e;
    int waited;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1 || d2_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid got %b/%b want 1/1", name, out_valid, d2_out_valid);
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard empty queue", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if ({out_gt_cnt, out_lt_cnt, out_eq_cnt} !== {e.gt, e.lt, e.eq}) begin
      errors++;
      $display("FAIL %s_cnt8 got gt=%0d lt=%0d eq=%0d want gt=%0d lt=%0d eq=%0d",
               name, out_gt_cnt, out_lt_cnt, out_eq_cnt, e.gt, e.lt, e.eq);
    end
    checks++;
    if ({d2_out_gt_cnt, d2_out_lt_cnt, d2_out_eq_cnt} !== {e.gt2, e.lt2, e.eq2}) begin
      errors++;
      $display("FAIL %s_cnt2 got gt=%0d lt=%0d eq=%0d want gt=%0d lt=%0d eq=%0d",
               name, d2_out_gt_cnt, d2_out_lt_cnt, d2_out_eq_cnt, e.gt2, e.lt2, e.eq2);
    end
    for (int i = 0; i < hold; i++) begin
      if (disturb) begin
        snap = 1'b1; in_valid = 1'b1; g = 1'b1; l = 1'b0;
      end
      tick();
      if (disturb) model_sample(1'b1, 1'b0);
      snap = 1'b0; in_valid = 1'b0; g = 1'b0;
      checks++;
      if ({out_valid, d2_out_valid, out_gt_cnt, out_lt_cnt, out_eq_cnt,
           d2_out_gt_cnt, d2_out_lt_cnt, d2_out_eq_cnt} !==
          {2'b11, e.gt, e.lt, e.eq, e.gt2, e.lt2, e.eq2}) begin
        errors++;
        $display("FAIL %s_hold%0d got v=%b eq=%0d eq2=%0d want v=1 eq=%0d eq2=%0d",
                 name, i, out_valid, out_eq_cnt, d2_out_eq_cnt, e.eq, e.eq2);
      end
    end
    // Release with snap asserted in the same cycle: that snap must be ignored.
    out_ready = 1'b1; snap = 1'b1;
    tick();
    out_ready = 1'b0; snap = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || d2_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release got %b/%b want 0/0", name, out_valid, d2_out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_gap got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; g = 1'b0; l = 1'b0;
    clear = 1'b0; snap = 1'b0; out_ready = 1'b0;
    m_gt = 0; m_lt = 0; m_eq = 0;
    repeat (2) tick();
    checks++;
    if ({out_valid, out_gt_cnt, out_lt_cnt, out_eq_cnt, streak_dir, streak_hit, err} !== '0 ||
        {d2_out_valid, d2_out_gt_cnt, d2_out_lt_cnt, d2_out_eq_cnt, d2_streak_dir,
         d2_streak_hit, d2_err} !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b dir=%b hit=%b err=%b want all 0",
               out_valid, streak_dir, streak_hit, err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_gt_streak();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0);
      checks++;
      if ({streak_hit, streak_dir} !== ((i == 3) ? 3'b101 : 3'b000)) begin
        errors++;
        $display("FAIL gt_run%0d got hit=%b dir=%b", i, streak_hit, streak_dir);
      end
    end
    tick();
    checks++;
    if ({streak_hit, streak_dir} !== 3'b001) begin
      errors++;
      $display("FAIL gt_pulse_end got hit=%b dir=%b want 0/01", streak_hit, streak_dir);
    end
    request_snap();
    check_snapshot("gt_streak", 0, 1'b0);
  endtask

  task automatic test_lt_streak();
    do_clear();
    for (int i = 0; i < 6; i++) begin
      send((i < 2) ? 1'b1 : 1'b0, (i < 2) ? 1'b0 : 1'b1);
      checks++;
      if ({streak_hit, streak_dir} !== ((i == 5) ? 3'b110 : 3'b000)) begin
        errors++;
        $display("FAIL lt_seq%0d got hit=%b dir=%b", i, streak_hit, streak_dir);
      end
    end
    request_snap();
    check_snapshot("lt_streak", 0, 1'b0);
    send(1'b0, 1'b1);
    checks++;
    if ({streak_hit, streak_dir} !== 3'b010) begin
      errors++;
      $display("FAIL lt_locked_hold got hit=%b dir=%b want 0/10", streak_hit, streak_dir);
    end
    send(1'b0, 1'b0);
    checks++;
    if ({streak_hit, streak_dir} !== 3'b000) begin
      errors++;
      $display("FAIL lt_break got hit=%b dir=%b want 0/00", streak_hit, streak_dir);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    repeat (6) send(1'b0, 1'b0);
    request_snap();
    check_snapshot("eq_sat", 5, 1'b1);
  endtask

  task automatic test_illegal();
    do_clear();
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    checks++;
    if ({err, streak_hit} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_err got err=%b hit=%b want 1/0", err, streak_hit);
    end
    send(1'b1, 1'b0);
    checks++;
    if (streak_hit !== 1'b0) begin
      errors++;
      $display("FAIL illegal_gt3 got hit=%b want 0", streak_hit);
    end
    send(1'b1, 1'b0);
    checks++;
    if ({err, streak_hit, streak_dir} !== 4'b1101) begin
      errors++;
      $display("FAIL illegal_gt4 got err=%b hit=%b dir=%b want 1/1/01", err, streak_hit, streak_dir);
    end
    request_snap();
    check_snapshot("illegal", 0, 1'b0);
    do_clear();
  endtask

  task automatic test_clear_snap();
    do_clear();
    repeat (5) send(1'b1, 1'b0);
    clear = 1'b1; snap = 1'b1; in_valid = 1'b1; g = 1'b1; l = 1'b0;
    push_expected();
    tick();
    clear = 1'b0; snap = 1'b0; in_valid = 1'b0; g = 1'b0;
    m_gt = 0; m_lt = 0; m_eq = 0;
    checks++;
    if ({streak_hit, streak_dir} !== 3'b000) begin
      errors++;
      $display("FAIL clear_snap_fsm got hit=%b dir=%b want 0/00", streak_hit, streak_dir);
    end
    check_snapshot("clear_snap", 1, 1'b0);
    request_snap();
    check_snapshot("post_clear", 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0);
      checks++;
      if (streak_hit !== (i == 3)) begin
        errors++;
        $display("FAIL restart_gt%0d got hit=%b", i, streak_hit);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_clear();
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid got %b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_gt_cnt, out_lt_cnt, out_eq_cnt, streak_dir, streak_hit, err} !== '0 ||
        d2_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b gt=%0d dir=%b want all 0", out_valid, out_gt_cnt, streak_dir);
    end
    sb.delete();
    m_gt = 0; m_lt = 0; m_eq = 0;
    #1 rst_n = 1'b1;
    send(1'b1, 1'b0);
    request_snap();
    check_snapshot("post_reset", 0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_gt_streak();
    test_lt_streak();
    test_saturation();
    test_illegal();
    test_clear_snap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
